// File: rtl/mp_add_sched_if.sv
// Requester/consumer bundle for the shared multi-precision add/subtract engine.
// Requesters and the consumer use the master view; the engine uses the slave view.
interface mp_add_sched_if #(
  parameter int NBYTES = 4
);
  localparam int W = 8 * NBYTES;

  logic         req0_valid;
  logic         req0_ready;
  logic [W-1:0] req0_a;
  logic [W-1:0] req0_b;
  logic         req0_sub;

  logic         req1_valid;
  logic         req1_ready;
  logic [W-1:0] req1_a;
  logic [W-1:0] req1_b;
  logic         req1_sub;

  logic         res_valid;
  logic         res_ready;
  logic [W-1:0] res_sum;
  logic         res_cout;
  logic         res_id;

  modport master (
    output req0_valid, req0_a, req0_b, req0_sub,
    output req1_valid, req1_a, req1_b, req1_sub,
    output res_ready,
    input  req0_ready, req1_ready,
    input  res_valid, res_sum, res_cout, res_id
  );

  modport slave (
    input  req0_valid, req0_a, req0_b, req0_sub,
    input  req1_valid, req1_a, req1_b, req1_sub,
    input  res_ready,
    output req0_ready, req1_ready,
    output res_valid, res_sum, res_cout, res_id
  );
endinterface

// File: rtl/mp_add_sched.sv
// Round-robin shared add/subtract engine: one 8-bit carry-in slice, LSB byte first,
// carry registered between beats, result held until the consumer takes it.
module mp_add_sched #(
  parameter int NBYTES = 4
) (
  input  logic                clk,
  input  logic                rst,
  mp_add_sched_if.slave       bus,
  output logic                busy
);
  localparam int W  = 8 * NBYTES;
  localparam int BW = $clog2(NBYTES) + 1;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]    state;
  logic [BW-1:0] beat;
  logic          carry;
  logic          last_grant;
  logic [W-1:0]  op_a;
  logic [W-1:0]  op_b;

  logic          grant_vld;
  logic          grant_id;
  logic          accept;
  logic          last_beat;
  logic [W-1:0]  sel_a;
  logic [W-1:0]  sel_b;
  logic          sel_sub;
  logic [8:0]    slice;

  function automatic logic [8:0] add_byte(input logic [7:0] a,
                                          input logic [7:0] b,
                                          input logic       cin);
    return {1'b0, a} + {1'b0, b} + {8'd0, cin};
  endfunction

  always_comb begin
    grant_vld = bus.req0_valid | bus.req1_valid;
    // On a tie the requester that did not win last time gets the slot.
    grant_id  = (bus.req0_valid && bus.req1_valid) ? ~last_grant : bus.req1_valid;
    sel_a     = grant_id ? bus.req1_a   : bus.req0_a;
    sel_b     = grant_id ? bus.req1_b   : bus.req0_b;
    sel_sub   = grant_id ? bus.req1_sub : bus.req0_sub;
    accept    = (state == S_IDLE) && grant_vld;
    bus.req0_ready = accept && !rst && !grant_id;
    bus.req1_ready = accept && !rst &&  grant_id;
    last_beat = (beat == BW'(NBYTES - 1));
    slice     = add_byte(op_a[7:0], op_b[7:0], carry);
    busy      = (state != S_IDLE);
  end

  // Operand shift registers: the current byte always sits at bit 0.
  always_ff @(posedge clk) begin
    if (accept) begin
      op_a <= sel_a;
      op_b <= sel_b ^ {W{sel_sub}};
    end else if (state == S_RUN) begin
      op_a <= op_a >> 8;
      op_b <= op_b >> 8;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= S_IDLE;
      beat          <= '0;
      carry         <= 1'b0;
      last_grant    <= 1'b1;
      bus.res_valid <= 1'b0;
      bus.res_sum   <= '0;
      bus.res_cout  <= 1'b0;
      bus.res_id    <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (grant_vld) begin
            carry       <= sel_sub;
            bus.res_id  <= grant_id;
            last_grant  <= grant_id;
            beat        <= '0;
            bus.res_sum <= '0;
            state       <= S_RUN;
          end
        end
        S_RUN: begin
          bus.res_sum[{beat, 3'b000} +: 8] <= slice[7:0];
          carry <= slice[8];
          beat  <= beat + 1'b1;
          if (last_beat) begin
            bus.res_cout  <= slice[8];
            bus.res_valid <= 1'b1;
            state         <= S_DONE;
          end
        end
        S_DONE: begin
          if (bus.res_ready) begin
            bus.res_valid <= 1'b0;
            state         <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_mp_add_sched.sv
// Directed bench for mp_add_sched (NBYTES=4): single ops, ripple carry, subtract,
// contention fairness, result backpressure and mid-operation reset.
module tb_mp_add_sched;
  localparam int NBYTES = 4;

  logic clk = 1'b0;
  logic rst;
  logic busy;
  int   ncmp = 0;
  int   nfail = 0;

  mp_add_sched_if #(.NBYTES(NBYTES)) bus ();

  mp_add_sched #(.NBYTES(NBYTES)) dut (
    .clk  (clk),
    .rst  (rst),
    .bus  (bus),
    .busy (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    ncmp++;
    assert (obs === exp)
    else begin
      nfail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_reqs();
    bus.req0_valid = 1'b0; bus.req0_a = '0; bus.req0_b = '0; bus.req0_sub = 1'b0;
    bus.req1_valid = 1'b0; bus.req1_a = '0; bus.req1_b = '0; bus.req1_sub = 1'b0;
  endtask

  task automatic drive(input bit id, input logic [31:0] a, input logic [31:0] b, input bit sub);
    if (id) begin
      bus.req1_valid = 1'b1; bus.req1_a = a; bus.req1_b = b; bus.req1_sub = sub;
    end else begin
      bus.req0_valid = 1'b1; bus.req0_a = a; bus.req0_b = b; bus.req0_sub = sub;
    end
  endtask

  task automatic wait_result(input string tag, output int n);
    n = 0;
    while (bus.res_valid !== 1'b1 && n < 20) begin
      step();
      n++;
    end
    chk({tag, "_latency"}, 64'(n), 64'(NBYTES));
  endtask

  task automatic do_op(input string tag, input bit id, input logic [31:0] a,
                       input logic [31:0] b, input bit sub,
                       input logic [31:0] es, input bit ec);
    int n;
    drive(id, a, b, sub);
    #1;
    chk({tag, "_rdy_own"},   64'(id ? bus.req1_ready : bus.req0_ready), 64'd1);
    chk({tag, "_rdy_other"}, 64'(id ? bus.req0_ready : bus.req1_ready), 64'd0);
    step();
    idle_reqs();
    chk({tag, "_busy"}, 64'(busy), 64'd1);
    wait_result(tag, n);
    chk({tag, "_sum"},  64'(bus.res_sum),  64'(es));
    chk({tag, "_cout"}, 64'(bus.res_cout), 64'(ec));
    chk({tag, "_id"},   64'(bus.res_id),   64'(id));
    step();
    chk({tag, "_vld_clr"}, 64'(bus.res_valid), 64'd0);
    chk({tag, "_idle"},    64'(busy),          64'd0);
  endtask

  initial begin
    int n;
    bit exp_id;
    logic [31:0] held_sum;

    idle_reqs();
    bus.res_ready = 1'b1;
    rst = 1'b1;
    bus.req0_valid = 1'b1;
    #2;
    // Reset state, with a pending request that must not see ready.
    chk("rst_res_valid", 64'(bus.res_valid),  64'd0);
    chk("rst_res_sum",   64'(bus.res_sum),    64'd0);
    chk("rst_res_cout",  64'(bus.res_cout),   64'd0);
    chk("rst_res_id",    64'(bus.res_id),     64'd0);
    chk("rst_busy",      64'(busy),           64'd0);
    chk("rst_rdy0",      64'(bus.req0_ready), 64'd0);
    chk("rst_rdy1",      64'(bus.req1_ready), 64'd0);
    bus.req0_valid = 1'b0;
    step();
    step();
    rst = 1'b0;
    step();

    do_op("add0",   1'b0, 32'h0000_00FF, 32'h0000_0001, 1'b0, 32'h0000_0100, 1'b0);
    do_op("ripple", 1'b1, 32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 32'h0000_0000, 1'b1);
    do_op("sub_bw", 1'b0, 32'h0000_0005, 32'h0000_0007, 1'b1, 32'hFFFF_FFFE, 1'b0);
    do_op("sub_ok", 1'b0, 32'h0000_0007, 32'h0000_0005, 1'b1, 32'h0000_0002, 1'b1);

    // Contention from reset: grants must alternate starting with requester 0.
    rst = 1'b1;
    #2;
    rst = 1'b0;
    step();
    drive(1'b0, 32'h1234_5678, 32'h1111_1111, 1'b0);
    drive(1'b1, 32'h8000_0000, 32'h8000_0001, 1'b0);
    exp_id = 1'b0;
    for (int r = 0; r < 4; r++) begin
      #1;
      n = 0;
      while (!(bus.req0_ready || bus.req1_ready) && n < 30) begin
        step();
        n++;
      end
      chk("rr_grant_seen", 64'(bus.req0_ready | bus.req1_ready), 64'd1);
      chk("rr_one_ready",  64'(bus.req0_ready & bus.req1_ready), 64'd0);
      chk("rr_grant_id",   64'(bus.req1_ready), 64'(exp_id));
      step();
      chk("rr_no_rdy_run", 64'(bus.req0_ready | bus.req1_ready), 64'd0);
      wait_result("rr", n);
      chk("rr_id",  64'(bus.res_id), 64'(exp_id));
      chk("rr_sum", 64'(bus.res_sum), exp_id ? 64'h0000_0001 : 64'h2345_6789);
      chk("rr_cout", 64'(bus.res_cout), exp_id ? 64'd1 : 64'd0);
      step();
      exp_id = ~exp_id;
    end
    idle_reqs();
    step();
    step();

    // Backpressure: result held while the consumer stalls; a new request waits.
    bus.res_ready = 1'b0;
    drive(1'b0, 32'h0000_FFFF, 32'h0000_0001, 1'b0);
    step();
    idle_reqs();
    wait_result("bp", n);
    held_sum = bus.res_sum;
    chk("bp_sum", 64'(held_sum), 64'h0001_0000);
    drive(1'b1, 32'h0000_0001, 32'h0000_0001, 1'b0);
    for (int c = 0; c < 5; c++) begin
      step();
      chk("bp_valid", 64'(bus.res_valid), 64'd1);
      chk("bp_hold_sum", 64'(bus.res_sum), 64'h0001_0000);
      chk("bp_hold_id_cout", {62'd0, bus.res_id, bus.res_cout}, 64'd0);
      chk("bp_no_rdy", 64'(bus.req0_ready | bus.req1_ready), 64'd0);
      chk("bp_busy", 64'(busy), 64'd1);
    end
    idle_reqs();
    bus.res_ready = 1'b1;
    step();
    chk("bp_rel_valid", 64'(bus.res_valid), 64'd0);
    chk("bp_rel_idle",  64'(busy),          64'd0);
    chk("bp_rel_sum",   64'(bus.res_sum),   64'h0001_0000);

    // Reset during RUN after two beats: partial result must vanish immediately.
    drive(1'b1, 32'h0101_0101, 32'h0101_0101, 1'b0);
    step();
    idle_reqs();
    step();
    step();
    chk("mr_partial", 64'(bus.res_sum), 64'h0000_0202);
    rst = 1'b1;
    #1;
    chk("mr_busy",  64'(busy),           64'd0);
    chk("mr_valid", 64'(bus.res_valid),  64'd0);
    chk("mr_sum",   64'(bus.res_sum),    64'd0);
    chk("mr_id",    64'(bus.res_id),     64'd0);
    chk("mr_cout",  64'(bus.res_cout),   64'd0);
    step();
    rst = 1'b0;
    for (int c = 0; c < 6; c++) begin
      step();
      chk("mr_no_result", 64'(bus.res_valid), 64'd0);
    end
    do_op("post_rst", 1'b0, 32'h0A0B_0C0D, 32'h0101_0101, 1'b0, 32'h0B0C_0D0E, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end
endmodule
